fma16_unpack: RTL and testbench
===============================

Name: fma16_unpack

Overview:
- Operand front end of the fp16 FMA datapath. Mirrors the rounding/pack stage at the datapath output.
- Accepts three binary16 operands (x, y, z) over a valid/ready handshake.
- Splits each operand into sign, signed biased exponent and 11-bit significand, classifies it, and normalizes subnormals with an iterative shifter.
- Delivers unpacked operands to the multiplier/adder stage over a second valid/ready handshake.

Parameters:
- SE_W, 7, width of signed biased exponent output (matches round-stage exponent width)
- BIAS, 15, binary16 exponent bias (informational; exponent outputs stay biased)

Ports:
- clk  in  1  clock, all logic rising-edge
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  operand triple valid
- in_ready  out  1  unit can accept a triple
- x, y, z  in  16 each  binary16 operands
- out_valid  out  1  unpacked triple valid
- out_ready  in  1  downstream accepts
- xs, ys, zs  out  1 each  sign
- xe, ye, ze  out  SE_W each  two's-complement biased exponent
- xm, ym, zm  out  11 each  significand, bit 10 = integer bit
- xflags, yflags, zflags  out  4 each  {snan, nan, inf, zero}

Behaviour:
- States: IDLE, NORM, DONE.
- Reset: reset_n low at an edge forces state IDLE and clears all outputs to 0 (out_valid=0). in_ready is 0 while reset_n is low. Reset mid-NORM or mid-DONE abandons the triple.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- A handshake (in_valid & in_ready) captures the fields.
  - Normal (e 1..30): s; e zero-extended to SE_W; m = {1,frac}.
  - Zero (e=0, frac=0): e=0, m=0, zero=1.
  - Subnormal (e=0, frac!=0): e=1, m = {0,frac}; marked for normalization.
  - Inf (e=31, frac=0): e=31, m=0, inf=1.
  - NaN (e=31, frac!=0): e=31, m = {0,frac}, nan=1; snan = ~frac[9].
- After capture: next state NORM if any operand is marked subnormal, else DONE.
- NORM: each cycle, every operand with its mark set and m[10]=0 shifts m left by 1 and decrements e by 1. The mark clears when m[10]=1. Leave NORM for DONE when no marks remain.
  - Max 10 shift cycles (frac=0x001 gives e=-9, i.e. 0x77).
  - Operands normalize in parallel; NORM dwell = max shift count over the three operands.
- DONE: out_valid=1. Outputs are held stable until out_ready.
  - On out_ready without a new capture, go to IDLE and drop out_valid.
  - On out_ready with a simultaneous in_valid, capture the new triple in the same cycle; no bubble for normal operands.
- Latency: capture at cycle N gives out_valid at N+1+k, where k = NORM shifts (0..10).
- Throughput: one triple per cycle when all operands are normal and out_ready is held high.
- Exponent arithmetic is SE_W-bit two's complement. It never underflows, since the minimum is -9.

Optional Feature:
- Macro: FMA16_UNPACK_FAST_NORM_EN.
- Defined: a leading-zero counter per operand normalizes in a single NORM cycle (shift by lzc, e -= lzc). Every subnormal-bearing triple has latency N+2.
- Undefined: iterative 1-bit shifting as above.
- Output values are identical in both builds; only timing differs.

Decomposition:
- fma16_pkg holds:
  - constants BIAS=15, EXP_MAX=31, SE_W=7
  - flag bit indices FLG_ZERO=0, FLG_INF=1, FLG_NAN=2, FLG_SNAN=3
  - typedef struct packed unpacked_t {s, e[SE_W-1:0], m[10:0], flags[3:0]}
  - state enum
- Sub-module fma16_classify: combinational field split and classification of one operand, returning unpacked_t plus a needs-norm bit. Instantiated three times; the FSM and shifters stay in the top.

Test Plan:
- x=0x3C00, y=0x4000, z=0x0000, out_ready=1, accept at cycle 0 -> out_valid at cycle 1. xe=15, xm=0x400, ye=16, ym=0x400, zflags=0001, ze=0, zm=0.
- x=0x0001, y=0x3C00, z=0x0200 -> 10 NORM cycles, out_valid at cycle 11. xe=0x77 (-9), xm=0x400; ze=0 (1 shift), zm=0x400. With FMA16_UNPACK_FAST_NORM_EN: out_valid at cycle 2, same values.
- x=0x7E00, y=0x7D00, z=0xFC00 -> xflags=0100, yflags=1100, ym=0x100, zs=1, ze=31, zflags=0010, latency 1.
- out_ready low for 5 cycles after out_valid -> outputs unchanged, in_ready=0. Raise out_ready together with in_valid (new triple 0x4400, 0x3C00, 0x3C00) -> new triple captured that cycle; xe=17 appears the next cycle.
- reset_n low for one cycle during NORM of x=0x0001 -> next cycle state IDLE, out_valid=0, all outputs 0, in_ready=1.
- 20 back-to-back normal triples with out_ready=1 -> out_valid high for 20 consecutive cycles, values in order.

Source files
------------

// File: rtl/fma16_pkg.sv
// fma16_pkg: shared constants, unpacked operand record and FSM states for the fp16 FMA front end
package fma16_pkg;
  localparam int BIAS = 15;
  localparam int EXP_MAX = 31;
  localparam int SE_W = 7;
  localparam int FLG_ZERO = 0;
  localparam int FLG_INF = 1;
  localparam int FLG_NAN = 2;
  localparam int FLG_SNAN = 3;
  typedef struct packed {
    logic s;
    logic [SE_W-1:0] e;
    logic [10:0] m;
    logic [3:0] flags;
  } unpacked_t;
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd11;
    for (int i = 0; i < 11; i++)
      if (v[i]) lzc11 = 4'(10 - i);
  endfunction
endpackage

// File: rtl/fma16_classify.sv
// fma16_classify: field split and classification of one binary16 operand
module fma16_classify import fma16_pkg::*; #(
  parameter int BIAS = 15
) (
  input  logic [15:0] a,
  output unpacked_t   u,
  output logic        sub
);
  localparam logic [4:0] EMAX = 5'(2 * BIAS + 1);
  logic [4:0] ex;
  logic [9:0] f;
  logic top, fz;
  assign ex = a[14:10];
  assign f = a[9:0];
  assign top = ex == EMAX;
  assign fz = f == 10'd0;
  always_comb begin
    u.s = a[15];
    u.e = ex == 5'd0 ? SE_W'(!fz) : SE_W'(ex);
    u.m = (ex == 5'd0 || top) ? {1'b0, f} : {1'b1, f};
    u.flags[FLG_ZERO] = ex == 5'd0 && fz;
    u.flags[FLG_INF] = top && fz;
    u.flags[FLG_NAN] = top && !fz;
    u.flags[FLG_SNAN] = top && !fz && !f[9];
    sub = ex == 5'd0 && !fz;
  end
endmodule

// File: rtl/fma16_unpack.sv
// fma16_unpack: binary16 operand unpack/normalize front end; FMA16_UNPACK_FAST_NORM_EN selects single-cycle normalization
module fma16_unpack import fma16_pkg::*; #(
  parameter int SE_W = 7,
  parameter int BIAS = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     x,
  input  logic [15:0]     y,
  input  logic [15:0]     z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            xs,
  output logic            ys,
  output logic            zs,
  output logic [SE_W-1:0] xe,
  output logic [SE_W-1:0] ye,
  output logic [SE_W-1:0] ze,
  output logic [10:0]     xm,
  output logic [10:0]     ym,
  output logic [10:0]     zm,
  output logic [3:0]      xflags,
  output logic [3:0]      yflags,
  output logic [3:0]      zflags
);
  state_t state, state_n;
  unpacked_t r [3];
  unpacked_t r_n [3];
  unpacked_t c [3];
  logic [15:0] op [3];
  logic [2:0] cn, mark, mark_n;
  logic take;
  assign op = '{x, y, z};
  for (genvar g = 0; g < 3; g++) begin : g_cls
    fma16_classify #(.BIAS(BIAS)) u_cls (.a(op[g]), .u(c[g]), .sub(cn[g]));
  end
  assign in_ready = reset_n && (state == IDLE || (state == DONE && out_ready));
  assign take = in_valid && in_ready;
  assign out_valid = state == DONE;
  always_comb begin
    r_n = r;
    mark_n = mark;
    if (take) begin
      r_n = c;
      mark_n = cn;
    end else if (state == NORM) begin
      for (int i = 0; i < 3; i++) begin
`ifdef FMA16_UNPACK_FAST_NORM_EN
        if (mark[i]) begin
          r_n[i].m = r[i].m << lzc11(r[i].m);
          r_n[i].e = r[i].e - SE_W'(lzc11(r[i].m));
        end
        mark_n[i] = 1'b0;
`else
        if (mark[i] && !r[i].m[10]) begin
          r_n[i].m = r[i].m << 1;
          r_n[i].e = r[i].e - SE_W'(1);
        end
        mark_n[i] = mark[i] && !r_n[i].m[10];
`endif
      end
    end
  end
  // a fresh capture overrides everything, including a DONE that is being drained
  assign state_n = take ? (|cn ? NORM : DONE) :
                   state == NORM ? (|mark_n ? NORM : DONE) :
                   (state == DONE && out_ready) ? IDLE : state;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      r <= '{default: '0};
      mark <= 3'd0;
    end else begin
      state <= state_n;
      r <= r_n;
      mark <= mark_n;
    end
  end
  assign {xs, xe, xm, xflags} = r[0];
  assign {ys, ye, ym, yflags} = r[1];
  assign {zs, ze, zm, zflags} = r[2];
endmodule

// File: tb/tb_fma16_unpack.sv
// tb_fma16_unpack: scoreboard bench for the fp16 operand unpack front end
module tb_fma16_unpack;
  logic clk = 0, reset_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [15:0] x = 0, y = 0, z = 0;
  logic xs, ys, zs;
  logic [6:0] xe, ye, ze;
  logic [10:0] xm, ym, zm;
  logic [3:0] xflags, yflags, zflags;
  int checks = 0, failures = 0;
  typedef struct {
    logic [68:0] v;
    int lat;
  } exp_t;
  exp_t q [$];
  logic [68:0] obs;
  assign obs = {xs, xe, xm, xflags, ys, ye, ym, yflags, zs, ze, zm, zflags};

  fma16_unpack dut (.clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .out_valid(out_valid), .out_ready(out_ready),
    .xs(xs), .ys(ys), .zs(zs), .xe(xe), .ye(ye), .ze(ze), .xm(xm), .ym(ym), .zm(zm),
    .xflags(xflags), .yflags(yflags), .zflags(zflags));

  always #5 clk = ~clk;

  function automatic logic [22:0] ref_op(input logic [15:0] a, output int k);
    logic [4:0] ex = a[14:10];
    logic [9:0] f = a[9:0];
    logic [6:0] e;
    logic [10:0] m;
    logic [3:0] fl;
    int p = 0;
    k = 0;
    if (ex == 5'd31) begin
      e = 7'd31;
      m = {1'b0, f};
      fl = (f == 0) ? 4'b0010 : (f[9] ? 4'b0100 : 4'b1100);
    end else if (ex == 0 && f == 0) begin
      e = 0; m = 0; fl = 4'b0001;
    end else if (ex == 0) begin
      for (int i = 0; i < 10; i++) if (f[i]) p = i;
      k = 10 - p;
      m = {1'b0, f} << k;
      e = 7'(1 - k);
      fl = 0;
    end else begin
      e = {2'b00, ex}; m = {1'b1, f}; fl = 0;
    end
    return {a[15], e, m, fl};
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    exp_t t;
    int k0, k1, k2, km;
    t.v = {ref_op(a, k0), ref_op(b, k1), ref_op(c, k2)};
    km = k0 > k1 ? k0 : k1;
    km = km > k2 ? km : k2;
`ifdef FMA16_UNPACK_FAST_NORM_EN
    t.lat = km > 0 ? 2 : 1;
`else
    t.lat = 1 + km;
`endif
    q.push_back(t);
    x = a; y = b; z = c; in_valid = 1;
  endtask

  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    exp_t t;
    int cnt = 1;
    @(posedge clk); #1;
    send(a, b, c);
    out_ready = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL run_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    while (!out_valid && cnt < 30) begin @(negedge clk); cnt++; end
    t = q.pop_front();
    checks++;
    if (cnt !== t.lat) begin failures++; $display("FAIL latency %h/%h/%h: got %0d want %0d", a, b, c, cnt, t.lat); end
    checks++;
    if (obs !== t.v) begin failures++; $display("FAIL values %h/%h/%h: got %h want %h", a, b, c, obs, t.v); end
    @(posedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b00) begin failures++; $display("FAIL reset_hs: got %b want 00", {in_ready, out_valid}); end
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_outs: got %h want 0", obs); end
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL reset_release: got %b want 10", {in_ready, out_valid}); end
  endtask

  task automatic test_normal;
    run_one(16'h3C00, 16'h4000, 16'h0000);
    checks++;
    if ({xe, xm, ye, zflags} !== {7'd15, 11'h400, 7'd16, 4'b0001}) begin
      failures++; $display("FAIL normal_const: got %h want %h", {xe, xm, ye, zflags}, {7'd15, 11'h400, 7'd16, 4'b0001});
    end
    run_one(16'hBBFF, 16'h7BFF, 16'h8400);
  endtask

  task automatic test_subnormal;
    run_one(16'h0001, 16'h3C00, 16'h0200);
    checks++;
    if ({xe, xm, ze, zm} !== {7'h77, 11'h400, 7'd0, 11'h400}) begin
      failures++; $display("FAIL subnorm_const: got %h want %h", {xe, xm, ze, zm}, {7'h77, 11'h400, 7'd0, 11'h400});
    end
    run_one(16'h83FF, 16'h0010, 16'h8000);
    run_one(16'h0155, 16'h0003, 16'h8001);
  endtask

  task automatic test_special;
    run_one(16'h7E00, 16'h7D00, 16'hFC00);
    checks++;
    if ({xflags, yflags, ym, zs, ze, zflags} !== {4'b0100, 4'b1100, 11'h100, 1'b1, 7'd31, 4'b0010}) begin
      failures++; $display("FAIL special_const: got %h want %h", {xflags, yflags, ym, zs, ze, zflags},
        {4'b0100, 4'b1100, 11'h100, 1'b1, 7'd31, 4'b0010});
    end
  endtask

  task automatic test_stall;
    exp_t t, t2;
    @(posedge clk); #1;
    send(16'h3C00, 16'h4000, 16'h3C00);
    out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    t = q.pop_front();
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b10) begin failures++; $display("FAIL stall_hs: got %b want 10", {out_valid, in_ready}); end
      checks++;
      if (obs !== t.v) begin failures++; $display("FAIL stall_hold: got %h want %h", obs, t.v); end
    end
    @(posedge clk); #1;
    out_ready = 1;
    send(16'h4400, 16'h3C00, 16'h3C00);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    t2 = q.pop_front();
    checks++;
    if ({out_valid, xe} !== {1'b1, 7'd17}) begin failures++; $display("FAIL stall_next: got %h want %h", {out_valid, xe}, {1'b1, 7'd17}); end
    checks++;
    if (obs !== t2.v) begin failures++; $display("FAIL stall_next_vals: got %h want %h", obs, t2.v); end
    @(posedge clk);
  endtask

  task automatic test_reset_norm;
    exp_t t;
    @(posedge clk); #1;
    send(16'h0001, 16'h3C00, 16'h3C00);
    out_ready = 1;
    t = q.pop_back();
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_norm_ready_low: got %b want 0", in_ready); end
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL rst_norm_hs: got %b want 10", {in_ready, out_valid}); end
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL rst_norm_outs: got %h want 0", obs); end
  endtask

  task automatic test_back_to_back;
    exp_t t;
    int valids = 0;
    out_ready = 1;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      if (i < 20)
        send({1'($urandom_range(1)), 5'($urandom_range(30, 1)), 10'($urandom)},
             {1'($urandom_range(1)), 5'($urandom_range(30, 1)), 10'($urandom)},
             {1'($urandom_range(1)), 5'($urandom_range(30, 1)), 10'($urandom)});
      else
        in_valid = 0;
      @(negedge clk);
      if (i > 0) begin
        if (out_valid) valids++;
        t = q.pop_front();
        checks++;
        if (obs !== t.v) begin failures++; $display("FAIL b2b_vals[%0d]: got %h want %h", i - 1, obs, t.v); end
      end
    end
    checks++;
    if (valids !== 20) begin failures++; $display("FAIL b2b_valid_run: got %0d want 20", valids); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_subnormal;
    test_special;
    test_stall;
    test_reset_norm;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
